fetch_sequencer: RTL

Parametrised instruction-fetch and run controller for the next-generation core. Owns the program counter, drives a synchronous instruction ROM with one-cycle read latency, and resolves direct and flag-conditional relative branches with a one-bubble squash. Adds downstream stall handling, a Start/Ack run handshake, and saturating cycle and retired-instruction counters. Sits between the instruction ROM and the decoder/control block.

---
 rtl/fetch_sequencer.sv | 69 ++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/ROM fetch with one-bubble branch squash, stall hold,
// Start/Ack run control and saturating cycle / retired-instruction counters.
module fetch_sequencer #(
  parameter int PC_W = 10,
  parameter int INST_W = 9,
  parameter int OFF_W = 5,
  parameter int CNT_W = 16,
  parameter int START_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic              BranchEn,
  input  logic              ConditionBranch,
  input  logic              Flag,
  input  logic [OFF_W-1:0]  BranchOffset,
  input  logic              Halt,
  output logic [PC_W-1:0]   RomAddr,
  input  logic [INST_W-1:0] RomData,
  output logic [INST_W-1:0] InstOut,
  output logic              InstValid,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Ack,
  output logic [CNT_W-1:0]  CycleCt,
  output logic [CNT_W-1:0]  InstCt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [PC_W-1:0] START = PC_W'(START_ADDR);
  state_t state;
  logic [PC_W-1:0] fpc, dpc, target;
  logic run, retire, halt_go, take;
  assign run = state == RUN;
  assign retire = run && InstValid && !Stall;
  assign halt_go = retire && Halt;
  assign take = retire && BranchEn && (!ConditionBranch || Flag);
  assign target = dpc + PC_W'(signed'(BranchOffset));
  // re-address the held word while stalled so RomData keeps presenting it
  assign RomAddr = run && Stall && InstValid ? dpc : fpc;
  assign InstOut = RomData;
  assign ProgCtr = dpc;
  assign Ack = state == DONE;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      fpc <= START;
      dpc <= START;
      InstValid <= 1'b0;
      CycleCt <= '0;
      InstCt <= '0;
    end else if (Start) begin
      state <= RUN;
      fpc <= START;
      InstValid <= 1'b0;
      CycleCt <= '0;
      InstCt <= '0;
    end else if (run) begin
      CycleCt <= CycleCt + CNT_W'(CycleCt != '1);
      InstCt <= InstCt + CNT_W'(retire && InstCt != '1);
      if (halt_go) begin
        state <= DONE;
        InstValid <= 1'b0;
      end else if (!Stall) begin
        dpc <= fpc;
        fpc <= take ? target : fpc + PC_W'(1);
        InstValid <= !take;
      end
    end
endmodule
